// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage RV32M execution unit.
// Multiplies finish two cycles after acceptance. Divide and remainder use an
// iterative restoring divider, one quotient bit per cycle. Divide-by-zero and
// signed overflow finish one cycle after acceptance. STALL holds the upstream
// pipeline registers while an operation is in flight.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            DONE,
    output logic            STALL,
    output logic            BUSY
);

    localparam int              CNT_W    = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    // Latched operation and operands
    logic [1:0]      op_sel_r;      // FUNC3[1:0] of the accepted op
    logic [XLEN-1:0] mul_a_r;
    logic [XLEN-1:0] mul_b_r;
    logic [XLEN-1:0] quo_r;         // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] rem_r;         // partial remainder
    logic [XLEN-1:0] dvs_r;         // |divisor|
    logic            quo_neg_r;     // quotient must be negated
    logic            rem_neg_r;     // remainder must be negated
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0] result_r;

    // Acceptance-time decode
    logic            accept_s;
    logic            div_zero_s;
    logic            div_ovf_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic [XLEN-1:0] a_abs_s;
    logic [XLEN-1:0] b_abs_s;
    logic [XLEN-1:0] early_res_s;

    // Multiplier datapath
    logic            mul_sa_s;
    logic            mul_sb_s;
    logic [2*XLEN-1:0] mul_opa_s;
    logic [2*XLEN-1:0] mul_opb_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0] mul_res_s;

    // Divider datapath
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;
    logic            ge_s;
    logic [XLEN-1:0] rem_next_s;
    logic [XLEN-1:0] quo_next_s;
    logic [XLEN-1:0] div_res_s;

    // Decode the incoming op and precompute the single-cycle special-case results
    always_comb begin
        accept_s    = (state_r == S_IDLE) & START & ~FLUSH;
        div_zero_s  = (DATA2 == ZERO);
        div_ovf_s   = ~FUNC3[0] & (DATA1 == MIN_NEG) & (DATA2 == ALL_ONES);
        a_neg_s     = ~FUNC3[0] & DATA1[XLEN-1];
        b_neg_s     = ~FUNC3[0] & DATA2[XLEN-1];
        a_abs_s     = a_neg_s ? (ZERO - DATA1) : DATA1;
        b_abs_s     = b_neg_s ? (ZERO - DATA2) : DATA2;
        if (div_zero_s) begin
            early_res_s = FUNC3[1] ? DATA1 : ALL_ONES;
        end else begin
            early_res_s = FUNC3[1] ? ZERO : MIN_NEG;
        end
    end

    // Full-width product; signedness of each operand selected by the latched op
    always_comb begin
        mul_sa_s  = (op_sel_r != 2'b11);          // MUL, MULH, MULHSU
        mul_sb_s  = (op_sel_r == 2'b01);          // MULH only
        mul_opa_s = {{XLEN{mul_sa_s & mul_a_r[XLEN-1]}}, mul_a_r};
        mul_opb_s = {{XLEN{mul_sb_s & mul_b_r[XLEN-1]}}, mul_b_r};
        prod_s    = mul_opa_s * mul_opb_s;
        if (op_sel_r == 2'b00) begin
            mul_res_s = prod_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // One restoring shift-subtract step plus the sign fix-up for the final load
    always_comb begin
        shifted_s  = {rem_r, quo_r[XLEN-1]};
        diff_s     = shifted_s - {1'b0, dvs_r};
        ge_s       = ~diff_s[XLEN];
        rem_next_s = ge_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
        quo_next_s = {quo_r[XLEN-2:0], ge_s};
        if (op_sel_r[1]) begin
            div_res_s = rem_neg_r ? (ZERO - rem_next_s) : rem_next_s;
        end else begin
            div_res_s = quo_neg_r ? (ZERO - quo_next_s) : quo_next_s;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; FLUSH overrides everything and returns to IDLE
    always_comb begin
        state_s = state_r;
        if (FLUSH) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!START) begin
                        state_s = S_IDLE;
                    end else if (!FUNC3[2]) begin
                        state_s = S_MUL;
                    end else if (div_zero_s || div_ovf_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_DIV;
                    end
                end
                S_MUL:  state_s = S_DONE;
                S_DIV: begin
                    if (cnt_r == CNT_ONE) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_DIV;
                    end
                end
                S_DONE: state_s = S_IDLE;
                default: state_s = S_IDLE;
            endcase
        end
    end

    // Operand latching, divider iteration and RESULT loading
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_sel_r  <= 2'b00;
            mul_a_r   <= ZERO;
            mul_b_r   <= ZERO;
            quo_r     <= ZERO;
            rem_r     <= ZERO;
            dvs_r     <= ZERO;
            quo_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            result_r  <= ZERO;
        end else if (!FLUSH) begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_sel_r <= FUNC3[1:0];
                        if (!FUNC3[2]) begin
                            mul_a_r <= DATA1;
                            mul_b_r <= DATA2;
                        end else if (div_zero_s || div_ovf_s) begin
                            result_r <= early_res_s;
                        end else begin
                            quo_r     <= a_abs_s;
                            rem_r     <= ZERO;
                            dvs_r     <= b_abs_s;
                            quo_neg_r <= a_neg_s ^ b_neg_s;
                            rem_neg_r <= a_neg_s;
                            cnt_r     <= CNT_INIT;
                        end
                    end
                end
                S_MUL: begin
                    result_r <= mul_res_s;
                end
                S_DIV: begin
                    quo_r <= quo_next_s;
                    rem_r <= rem_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result_r <= div_res_s;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    // Output drive; STALL is combinational so it drops in the DONE cycle
    always_comb begin
        RESULT = result_r;
        DONE   = (state_r == S_DONE);
        BUSY   = (state_r != S_IDLE);
        STALL  = ~RESET & ~FLUSH &
                 (((state_r == S_IDLE) & START) | (state_r == S_MUL) | (state_r == S_DIV));
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic        FLUSH;
    logic [2:0]  FUNC3;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [31:0] RESULT;
    logic        DONE;
    logic        STALL;
    logic        BUSY;

    int errors;
    int checks;
    logic [31:0] exp_last;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH), .FUNC3(FUNC3),
        .DATA1(DATA1), .DATA2(DATA2), .RESULT(RESULT), .DONE(DONE),
        .STALL(STALL), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: RISC-V M semantics from plain arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: return a * b;
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b}; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 32'h0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one op (START held until DONE) and report what was observed
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int done_cyc, output int stall_bad);
        done_cyc  = -1;
        stall_bad = 0;
        res       = 32'h0;
        @(negedge CLK);
        START = 1'b1; FUNC3 = f3; DATA1 = a; DATA2 = b;
        for (int c = 0; c < 100; c++) begin
            if (c == 1) begin
                FUNC3 = 3'($urandom); DATA1 = $urandom; DATA2 = $urandom;
            end
            #1;
            if (DONE === 1'b1) begin
                done_cyc = c;
                res = RESULT;
                if (STALL !== 1'b0) stall_bad++;
                START = 1'b0;
                break;
            end
            if (STALL !== 1'b1) stall_bad++;
            @(negedge CLK);
        end
        START = 1'b0;
    endtask

    // Run one op and compare result, latency and stall pattern against the model
    task automatic check_op_inline_free(input string name, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        int dc;
        int sb;
        logic [31:0] er;
        int el;
        er = ref_result(f3, a, b);
        el = ref_latency(f3, a, b);
        do_op(f3, a, b, res, dc, sb);
        checks++;
        if (res !== er) begin
            errors++;
            $display("FAIL %s result: got %h expected %h (f3=%0d a=%h b=%h)", name, res, er, f3, a, b);
        end
        checks++;
        if (dc != el) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, dc, el);
        end
        checks++;
        if (sb != 0) begin
            errors++;
            $display("FAIL %s stall: %0d bad cycles expected 0", name, sb);
        end
        exp_last = er;
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b1; FLUSH = 1'b0; FUNC3 = 3'd0; DATA1 = 32'd5; DATA2 = 32'd6;
        @(negedge CLK); @(negedge CLK); #1;
        checks++;
        if (RESULT !== 32'h0 || DONE !== 1'b0 || BUSY !== 1'b0 || STALL !== 1'b0) begin
            errors++;
            $display("FAIL reset: got RESULT=%h DONE=%b BUSY=%b STALL=%b expected 0/0/0/0", RESULT, DONE, BUSY, STALL);
        end
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0;
        exp_last = 32'h0;
    endtask

    task automatic test_mul;
        check_op_inline_free("mul_7x-3",  3'd0, 32'd7, 32'hFFFF_FFFD);
        check_op_inline_free("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000);
        check_op_inline_free("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_op_inline_free("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2);
        checks++;
        if (exp_last !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mulhsu_const: model %h expected ffffffff", exp_last);
        end
    endtask

    task automatic test_div;
        check_op_inline_free("divu_100_7", 3'd5, 32'd100, 32'd7);
        check_op_inline_free("remu_100_7", 3'd7, 32'd100, 32'd7);
        check_op_inline_free("div_-7_2",   3'd4, 32'hFFFF_FFF9, 32'd2);
        check_op_inline_free("rem_-7_2",   3'd6, 32'hFFFF_FFF9, 32'd2);
        check_op_inline_free("divu_max_1", 3'd5, 32'hFFFF_FFFF, 32'd1);
        check_op_inline_free("rem_7_-2",   3'd6, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_special;
        check_op_inline_free("div_by_0",  3'd4, 32'd5, 32'd0);
        check_op_inline_free("remu_by_0", 3'd7, 32'd5, 32'd0);
        check_op_inline_free("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op_inline_free("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check_op_inline_free("divu_nov",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_flush;
        logic saw_done;
        saw_done = 1'b0;
        @(negedge CLK);
        START = 1'b1; FUNC3 = 3'd5; DATA1 = 32'd100; DATA2 = 32'd7;
        for (int c = 0; c <= 11; c++) begin
            if (c == 10) FLUSH = 1'b1;
            if (c == 11) begin START = 1'b0; FLUSH = 1'b0; end
            #1;
            if (DONE === 1'b1) saw_done = 1'b1;
            if (c == 10) begin
                checks++;
                if (STALL !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_stall: got %b expected 0", STALL);
                end
            end
            if (c == 11) begin
                checks++;
                if (BUSY !== 1'b0 || RESULT !== exp_last) begin
                    errors++;
                    $display("FAIL flush_idle: got BUSY=%b RESULT=%h expected 0/%h", BUSY, RESULT, exp_last);
                end
            end
            @(negedge CLK);
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_nodone: got DONE seen=%b expected 0", saw_done);
        end
        check_op_inline_free("mul_after_flush", 3'd0, 32'd3, 32'd4);
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        START = 1'b1; FUNC3 = 3'd5; DATA1 = 32'd100; DATA2 = 32'd7;
        for (int c = 0; c < 15; c++) @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if (RESULT !== 32'h0 || BUSY !== 1'b0 || STALL !== 1'b0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got RESULT=%h BUSY=%b STALL=%b DONE=%b expected 0/0/0/0", RESULT, BUSY, STALL, DONE);
        end
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0;
        exp_last = 32'h0;
    endtask

    task automatic test_back_to_back;
        check_op_inline_free("b2b_divu_a", 3'd5, 32'd1000, 32'd9);
        check_op_inline_free("b2b_divu_b", 3'd5, 32'hDEAD_BEEF, 32'd12345);
    endtask

    task automatic test_random;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 255));
            check_op_inline_free("random", f3, a, b);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
